// File: rtl/dmem_resp.sv
// Data-memory responder for the nano_rv32i data port: word RAM with byte/half/word access and wait states.
// Optional misalignment checking is enabled by defining DMEM_MISALIGN_CHK_EN.
module dmem_resp #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_data_i,
    input  logic        d_rd_i,
    input  logic        d_wr_i,
    input  logic [1:0]  d_size_i,
    input  logic        d_unsigned_i,
    output logic [31:0] d_data_o,
    output logic        d_ready_o,
    output logic        d_err_o
);
    // state  | meaning
    // S_IDLE | no access in flight
    // S_WAIT | access accepted, counting wait states
    // S_DONE | access completed on the last edge, d_ready_o high
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

    localparam int         WORDS     = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [31:0] mem [WORDS];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic        uns_q, wr_q;
    logic [31:0] data_q, data_d;
    logic        ready_q, ready_d, err_q, err_d;

    logic                  req, complete, we, misalign;
    logic [31:0]           op_addr, op_wdata, rword, b_sh, h_sh, load_val, wlanes;
    logic [1:0]            op_size;
    logic                  op_uns, op_wr;
    logic [DEPTH_LOG2-1:0] idx;
    logic [3:0]            be;
    logic                  unused_addr_bits;

    assign req = d_rd_i | d_wr_i;

    // With zero wait states the access completes on the accepting edge, so it uses the live inputs.
    always_comb begin
        op_addr  = d_addr_i;
        op_wdata = d_data_i;
        op_size  = d_size_i;
        op_uns   = d_unsigned_i;
        op_wr    = d_wr_i;
        if (state_q == S_WAIT) begin
            op_addr  = addr_q;
            op_wdata = wdata_q;
            op_size  = size_q;
            op_uns   = uns_q;
            op_wr    = wr_q;
        end
    end

    assign idx              = op_addr[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^op_addr[31:DEPTH_LOG2+2];
    assign rword            = mem[idx];
    assign b_sh             = rword >> {op_addr[1:0], 3'b000};
    assign h_sh             = rword >> {op_addr[1], 4'b0000};

    always_comb begin
        be       = 4'b1111;
        wlanes   = op_wdata;
        load_val = rword;
        misalign = 1'b0;
        case (op_size)
            2'b00: begin
                be       = 4'b0001 << op_addr[1:0];
                wlanes   = {4{op_wdata[7:0]}};
                load_val = op_uns ? {24'b0, b_sh[7:0]} : {{24{b_sh[7]}}, b_sh[7:0]};
            end
            2'b01: begin
                be       = op_addr[1] ? 4'b1100 : 4'b0011;
                wlanes   = {2{op_wdata[15:0]}};
                load_val = op_uns ? {16'b0, h_sh[15:0]} : {{16{h_sh[15]}}, h_sh[15:0]};
`ifdef DMEM_MISALIGN_CHK_EN
                misalign = op_addr[0];
`endif
            end
            default: begin
`ifdef DMEM_MISALIGN_CHK_EN
                misalign = |op_addr[1:0];
`endif
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        complete = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d  = S_DONE;
                        complete = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d  = S_DONE;
                    complete = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = complete;
        err_d   = complete & misalign;
        data_d  = data_q;
        if (complete && !op_wr) begin
            data_d = misalign ? 32'b0 : load_val;
        end
    end

    // Reset wins over a completing store, so an access interrupted by reset never reaches the RAM.
    assign we = complete & op_wr & ~misalign & rst_n_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
            size_q  <= 2'b0;
            uns_q   <= 1'b0;
            wr_q    <= 1'b0;
            data_q  <= 32'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            if (state_q != S_WAIT && req) begin
                addr_q  <= d_addr_i;
                wdata_q <= d_data_i;
                size_q  <= d_size_i;
                uns_q   <= d_unsigned_i;
                wr_q    <= d_wr_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    assign d_data_o  = data_q;
    assign d_ready_o = ready_q;
    assign d_err_o   = err_q;
endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: a zero-wait and a three-wait instance share one request stream,
// each with its own byte-level memory model and response queue.
module tb_dmem_resp;
    localparam int DL = 8;
    localparam int WB = 3;
    localparam int NB = 4 << DL;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr, wdata;
    logic        rd, wr, uns;
    logic [1:0]  size;
    logic [31:0] data0, data1;
    logic        rdy0, rdy1, err0, err1;

    dmem_resp #(.DEPTH_LOG2(DL), .WAIT_CYCLES(0)) u_d0 (
        .clk_i(clk), .rst_n_i(rst_n), .d_addr_i(addr), .d_data_i(wdata), .d_rd_i(rd), .d_wr_i(wr),
        .d_size_i(size), .d_unsigned_i(uns), .d_data_o(data0), .d_ready_o(rdy0), .d_err_o(err0));
    dmem_resp #(.DEPTH_LOG2(DL), .WAIT_CYCLES(WB)) u_d1 (
        .clk_i(clk), .rst_n_i(rst_n), .d_addr_i(addr), .d_data_i(wdata), .d_rd_i(rd), .d_wr_i(wr),
        .d_size_i(size), .d_unsigned_i(uns), .d_data_o(data1), .d_ready_o(rdy1), .d_err_o(err1));

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  mb [2][NB];
    logic [31:0] last [2];
    logic [32:0] expq0 [$];
    logic [32:0] expq1 [$];
    logic [32:0] e0, e1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte-addressed reference: returns {err, d_data_o after the access}.
    function automatic logic [32:0] model(int d, logic w, logic [1:0] sz, logic u,
                                          logic [31:0] a, logic [31:0] wd);
        int n, base;
        logic [31:0] v;
        n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        base = int'(a[DL+1:0]);
`ifdef DMEM_MISALIGN_CHK_EN
        if ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00)) begin
            if (!w) last[d] = 32'b0;
            return {1'b1, last[d]};
        end
`else
        base = base - (base % n);
`endif
        if (w) begin
            for (int i = 0; i < n; i++) mb[d][base+i] = wd[8*i +: 8];
        end else begin
            v = 32'b0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = mb[d][base+i];
            if (!u && n < 4 && v[8*n-1]) begin
                for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
            end
            last[d] = v;
        end
        return {1'b0, last[d]};
    endfunction

    always @(negedge clk) begin
        if (rdy0 === 1'b1) begin
            if (expq0.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL ready0_unexpected: got ready=1 expected no response");
            end else begin
                e0 = expq0.pop_front();
                check("data0", data0, e0[31:0]);
                check("err0", {31'b0, err0}, {31'b0, e0[32]});
            end
        end
        if (rdy1 === 1'b1) begin
            if (expq1.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL ready1_unexpected: got ready=1 expected no response");
            end else begin
                e1 = expq1.pop_front();
                check("data1", data1, e1[31:0]);
                check("err1", {31'b0, err1}, {31'b0, e1[32]});
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_data0", data0, 32'b0);
        check("rst_rdy0", {31'b0, rdy0}, 32'b0);
        check("rst_err0", {31'b0, err0}, 32'b0);
        check("rst_data1", data1, 32'b0);
        check("rst_rdy1", {31'b0, rdy1}, 32'b0);
        check("rst_err1", {31'b0, err1}, 32'b0);
    endtask

    // Called at a falling edge; returns at the falling edge where the slow instance shows ready.
    task automatic do_req(logic r, logic w, logic [1:0] sz, logic u, logic [31:0] a, logic [31:0] wd);
        int ca, cb;
        rd = r; wr = w; size = sz; uns = u; addr = a; wdata = wd;
        expq0.push_back(model(0, w, sz, u, a, wd));
        expq1.push_back(model(1, w, sz, u, a, wd));
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0; addr = $urandom; wdata = $urandom;
        size = 2'($urandom_range(0, 3)); uns = 1'($urandom_range(0, 1));
        ca = 0; cb = 0;
        for (int k = 1; k <= 20 && cb == 0; k++) begin
            @(negedge clk);
            if (rdy0 && ca == 0) ca = k;
            if (rdy1) cb = k;
        end
        check("latency0", 32'(ca), 32'd1);
        check("latency1", 32'(cb), 32'(WB + 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rd = 1'b0; wr = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'b0; wdata = 32'b0;
        last[0] = 32'b0; last[1] = 32'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_reset_outputs();

        do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("deadbeef", data1, 32'hDEADBEEF);

        for (int w = 0; w < NB / 4; w++) do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'(4 * w), $urandom);

        do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
        do_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h12345680);
        do_req(1'b1, 1'b0, 2'b10, 1'b1, 32'h10, 32'h0);
        check("byte_word", data1, 32'h80223344);
        do_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        check("byte_signed", data1, 32'hFFFFFF80);
        do_req(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        check("byte_unsigned", data0, 32'h00000080);

        do_req(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h9999BEEF);
        do_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
        check("half_signed", data1, 32'hFFFFBEEF);
        do_req(1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
        check("half_unsigned", data1, 32'h0000BEEF);
        do_req(1'b1, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
        do_req(1'b1, 1'b1, 2'b10, 1'b0, 32'h24, 32'h0BADF00D);

        // Byte store aborted by reset while the slow instance is still waiting.
        rd = 1'b0; wr = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h40; wdata = 32'h55;
        expq0.push_back(model(0, 1'b1, 2'b00, 1'b0, 32'h40, 32'h55));
        @(posedge clk);
        #1;
        wr = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last[0] = 32'b0; last[1] = 32'b0;
        check_reset_outputs();
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);

        do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'(32'h40 + NB), 32'hCAFEF00D);
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        check("alias", data1, 32'hCAFEF00D);
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'hFFFF_0040, 32'h0);

        do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h21, 32'hAAAAAAAA);
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        do_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h23, 32'h0);
        do_req(1'b1, 1'b0, 2'b11, 1'b0, 32'h22, 32'h0);

        for (int i = 0; i < 400; i++) begin
            int op;
            op = int'($urandom_range(0, 2));
            do_req(op != 1, op != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom);
        end

        repeat (5) @(negedge clk);
        check("queue0_drained", 32'(expq0.size()), 32'd0);
        check("queue1_drained", 32'(expq1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
